// File: rtl/systolic_matmul_nxn.sv
// Output-stationary N x N systolic matrix multiplier, C = A x B.
// Operands are latched on start and skewed into the array; the result is held in c_flat.
module systolic_matmul_nxn #(
  parameter int N      = 3,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  parameter int AW     = 2*DW + $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N*N*DW-1:0]   a_flat,
  input  logic [N*N*DW-1:0]   b_flat,
  output logic                busy,
  output logic                done,
  output logic [N*N*AW-1:0]   c_flat
);

  localparam int            CW   = $clog2(3*N);
  localparam logic [CW-1:0] LAST = CW'(3*N - 2);
  localparam bit            SGN  = (SIGNED != 0);
  localparam int            XW   = AW - 2*DW;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic [N*N*DW-1:0]   a_lat_r;
  logic [N*N*DW-1:0]   b_lat_r;
  logic [DW-1:0]       a_pipe_r [N][N];
  logic [DW-1:0]       b_pipe_r [N][N];
  logic [AW-1:0]       acc_r    [N][N];
  logic [DW-1:0]       edge_a_s [N];
  logic [DW-1:0]       edge_b_s [N];
  logic [DW-1:0]       a_in_s   [N][N];
  logic [DW-1:0]       b_in_s   [N][N];
  logic [AW-1:0]       prod_s   [N][N];
  logic                accept_s;

  // A start in the cycle done is high is deliberately not accepted.
  assign accept_s = (state_r == IDLE) && start && !done;

  // Skewed edge feed: row i of A and column i of B enter i steps late, zero outside the window.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      edge_a_s[i] = '0;
      edge_b_s[i] = '0;
      if ((state_r == RUN) && (int'(cnt_r) >= i) && (int'(cnt_r) < i + N)) begin
        edge_a_s[i] = a_lat_r[(i*N + int'(cnt_r) - i)*DW +: DW];
        edge_b_s[i] = b_lat_r[((int'(cnt_r) - i)*N + i)*DW +: DW];
      end else begin
        edge_a_s[i] = '0;
        edge_b_s[i] = '0;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [2*DW-1:0] ax_s;
      logic [2*DW-1:0] bx_s;
      logic [2*DW-1:0] p_s;
      if (gj == 0) begin : g_a_edge
        assign a_in_s[gi][gj] = edge_a_s[gi];
      end else begin : g_a_int
        assign a_in_s[gi][gj] = a_pipe_r[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in_s[gi][gj] = edge_b_s[gj];
      end else begin : g_b_int
        assign b_in_s[gi][gj] = b_pipe_r[gi-1][gj];
      end
      // Extending both operands to 2*DW makes one multiplier exact for either signedness.
      assign ax_s = {{DW{SGN & a_in_s[gi][gj][DW-1]}}, a_in_s[gi][gj]};
      assign bx_s = {{DW{SGN & b_in_s[gi][gj][DW-1]}}, b_in_s[gi][gj]};
      assign p_s  = ax_s * bx_s;
      assign prod_s[gi][gj] = {{XW{SGN & p_s[2*DW-1]}}, p_s};
    end
  end

  // Operand latches, PE forwarding registers and accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat_r <= '0;
      b_lat_r <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_pipe_r[i][j] <= '0;
          b_pipe_r[i][j] <= '0;
          acc_r[i][j]    <= '0;
        end
      end
    end else if (accept_s) begin
      a_lat_r <= a_flat;
      b_lat_r <= b_flat;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_pipe_r[i][j] <= '0;
          b_pipe_r[i][j] <= '0;
          acc_r[i][j]    <= '0;
        end
      end
    end else if (state_r == RUN) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_pipe_r[i][j] <= a_in_s[i][j];
          b_pipe_r[i][j] <= b_in_s[i][j];
          acc_r[i][j]    <= acc_r[i][j] + prod_s[i][j];
        end
      end
    end else begin
      a_lat_r <= a_lat_r;
    end
  end

  // Control FSM with registered busy/done and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      c_flat  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (accept_s) begin
            state_r <= RUN;
            cnt_r   <= '0;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (cnt_r == LAST) begin
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              c_flat[(i*N + j)*AW +: AW] <= acc_r[i][j];
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Directed bench for systolic_matmul_nxn: 3x3 unsigned, 3x3 signed and 4x4 4-bit instances.
module tb_systolic_matmul_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_u, start_s, start_4;
  logic         busy_u, busy_s, busy_4;
  logic         done_u, done_s, done_4;
  logic [71:0]  a_u, b_u, a_s, b_s;
  logic [161:0] c_u, c_s;
  logic [63:0]  a_4, b_4;
  logic [159:0] c_4;

  int vectors = 0;
  int miscompares = 0;

  systolic_matmul_nxn #(.N(3), .DW(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(start_u), .a_flat(a_u), .b_flat(b_u),
    .busy(busy_u), .done(done_u), .c_flat(c_u));

  systolic_matmul_nxn #(.N(3), .DW(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a_flat(a_s), .b_flat(b_s),
    .busy(busy_s), .done(done_s), .c_flat(c_s));

  systolic_matmul_nxn #(.N(4), .DW(4), .SIGNED(0)) dut_4 (
    .clk(clk), .rst_n(rst_n), .start(start_4), .a_flat(a_4), .b_flat(b_4),
    .busy(busy_4), .done(done_4), .c_flat(c_4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic dn(input int w);
    case (w)
      0: return done_u;
      1: return done_s;
      default: return done_4;
    endcase
  endfunction

  // Start must already be high; returns the cycle (counted from the start edge) in which done is seen.
  task automatic wait_done(input int w, output int cyc);
    step();
    start_u = 1'b0; start_s = 1'b0; start_4 = 1'b0;
    cyc = 1;
    while (!dn(w) && cyc < 60) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_u = 1'b0; start_s = 1'b0; start_4 = 1'b0;
    a_u = '0; b_u = '0; a_s = '0; b_s = '0; a_4 = '0; b_4 = '0;
    step(); step();
    vectors++;
    if ({busy_u, busy_s, busy_4, done_u, done_s, done_4} !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000000", {busy_u, busy_s, busy_4, done_u, done_s, done_4});
    end
    vectors++;
    if (c_u !== '0 || c_s !== '0 || c_4 !== '0) begin
      miscompares++;
      $display("FAIL reset_c: got c_u=%h c_s=%h c_4=%h expected all zero", c_u, c_s, c_4);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic load_identity_u();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        a_u[(i*3+j)*8 +: 8] = (i == j) ? 8'd1 : 8'd0;
        b_u[(i*3+j)*8 +: 8] = 8'(i*3 + j + 1);
      end
  endtask

  task automatic check_c_u_seq(input string nm);
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (c_u[k*18 +: 18] !== 18'(k + 1)) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %0d expected %0d", nm, k, c_u[k*18 +: 18], k + 1);
      end
    end
  endtask

  task automatic test_identity();
    int cyc;
    load_identity_u();
    start_u = 1'b1;
    wait_done(0, cyc);
    vectors++;
    if (cyc !== 10) begin
      miscompares++;
      $display("FAIL identity_latency: got %0d expected 10", cyc);
    end
    vectors++;
    if (busy_u !== 1'b0) begin
      miscompares++;
      $display("FAIL identity_busy_with_done: got %b expected 0", busy_u);
    end
    check_c_u_seq("identity_c");
    step();
    vectors++;
    if (done_u !== 1'b0) begin
      miscompares++;
      $display("FAIL done_one_cycle: got %b expected 0", done_u);
    end
  endtask

  task automatic test_max_unsigned();
    int cyc;
    a_u = {9{8'd255}};
    b_u = {9{8'd255}};
    start_u = 1'b1;
    wait_done(0, cyc);
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (c_u[k*18 +: 18] !== 18'd195075) begin
        miscompares++;
        $display("FAIL max_unsigned[%0d]: got %0d expected 195075", k, c_u[k*18 +: 18]);
      end
    end
  endtask

  task automatic test_signed();
    int cyc;
    logic signed [17:0] neg_exp;
    neg_exp = -18'sd48768;
    a_s = {9{8'h80}};
    b_s = {9{8'h80}};
    start_s = 1'b1;
    wait_done(1, cyc);
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (c_s[k*18 +: 18] !== 18'd49152) begin
        miscompares++;
        $display("FAIL signed_pos[%0d]: got %0d expected 49152", k, c_s[k*18 +: 18]);
      end
    end
    step();
    b_s = {9{8'h7F}};
    start_s = 1'b1;
    wait_done(1, cyc);
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if ($signed(c_s[k*18 +: 18]) !== neg_exp) begin
        miscompares++;
        $display("FAIL signed_neg[%0d]: got %0d expected -48768", k, $signed(c_s[k*18 +: 18]));
      end
    end
  endtask

  task automatic test_start_held();
    int nd, d1, d2, cyc;
    step();
    load_identity_u();
    nd = 0; d1 = 0; d2 = 0;
    start_u = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (done_u) begin
        nd++;
        if (nd == 1) d1 = c;
        else if (nd == 2) d2 = c;
      end
    end
    start_u = 1'b0;
    vectors++;
    if (nd !== 2 || d1 !== 10 || d2 !== 21) begin
      miscompares++;
      $display("FAIL start_held: got %0d pulses at %0d,%0d expected 2 pulses at 10,21", nd, d1, d2);
    end
    cyc = 0;
    while (!done_u && cyc < 20) begin
      step();
      cyc++;
    end
    vectors++;
    if (done_u !== 1'b1) begin
      miscompares++;
      $display("FAIL start_held_third: got done=%b expected 1 within 20 cycles", done_u);
    end
    check_c_u_seq("start_held_c");
  endtask

  task automatic test_start_ignored();
    int cyc, nd;
    step();
    a_u = {9{8'd2}};
    b_u = {9{8'd3}};
    start_u = 1'b1;
    step();
    start_u = 1'b0;
    step(); step();
    start_u = 1'b1;
    step();
    start_u = 1'b0;
    cyc = 4;
    while (!done_u && cyc < 60) begin
      step();
      cyc++;
    end
    vectors++;
    if (cyc !== 10) begin
      miscompares++;
      $display("FAIL ignored_latency: got %0d expected 10", cyc);
    end
    start_u = 1'b1;
    step();
    start_u = 1'b0;
    vectors++;
    if (busy_u !== 1'b0) begin
      miscompares++;
      $display("FAIL start_on_done_accepted: got busy=%b expected 0", busy_u);
    end
    nd = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (done_u || busy_u) nd++;
    end
    vectors++;
    if (nd !== 0) begin
      miscompares++;
      $display("FAIL extra_activity: got %0d busy/done cycles expected 0", nd);
    end
    vectors++;
    if (c_u[0 +: 18] !== 18'd18) begin
      miscompares++;
      $display("FAIL ignored_c: got %0d expected 18", c_u[0 +: 18]);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc, nd;
    load_identity_u();
    start_u = 1'b1;
    step();
    start_u = 1'b0;
    for (int c = 0; c < 5; c++) step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy_u !== 1'b0 || done_u !== 1'b0 || c_u !== '0) begin
      miscompares++;
      $display("FAIL reset_midrun: got busy=%b done=%b c=%h expected 0 0 0", busy_u, done_u, c_u);
    end
    step(); step();
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (done_u) nd++;
    end
    vectors++;
    if (nd !== 0) begin
      miscompares++;
      $display("FAIL aborted_done: got %0d pulses expected 0", nd);
    end
    a_u = {9{8'd2}};
    b_u = {9{8'd3}};
    start_u = 1'b1;
    wait_done(0, cyc);
    vectors++;
    if (cyc !== 10) begin
      miscompares++;
      $display("FAIL after_reset_latency: got %0d expected 10", cyc);
    end
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (c_u[k*18 +: 18] !== 18'd18) begin
        miscompares++;
        $display("FAIL after_reset_c[%0d]: got %0d expected 18", k, c_u[k*18 +: 18]);
      end
    end
  endtask

  task automatic test_n4();
    int cyc;
    logic [159:0] snap;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_4[(i*4+j)*4 +: 4] = (i == j) ? 4'd1 : 4'd0;
        b_4[(i*4+j)*4 +: 4] = 4'(i*4 + j);
      end
    start_4 = 1'b1;
    wait_done(2, cyc);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (c_4[k*10 +: 10] !== 10'(k)) begin
        miscompares++;
        $display("FAIL n4_identity[%0d]: got %0d expected %0d", k, c_4[k*10 +: 10], k);
      end
    end
    step();
    snap = c_4;
    a_4 = {16{4'd15}};
    b_4 = {16{4'd15}};
    start_4 = 1'b1;
    step();
    start_4 = 1'b0;
    a_4 = '0;
    b_4 = '0;
    cyc = 1;
    while (!done_4 && cyc < 60) begin
      vectors++;
      if (c_4 !== snap) begin
        miscompares++;
        $display("FAIL n4_hold_cycle%0d: got %h expected %h", cyc, c_4, snap);
      end
      step();
      cyc++;
    end
    vectors++;
    if (cyc !== 13) begin
      miscompares++;
      $display("FAIL n4_latency: got %0d expected 13", cyc);
    end
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (c_4[k*10 +: 10] !== 10'd900) begin
        miscompares++;
        $display("FAIL n4_max[%0d]: got %0d expected 900", k, c_4[k*10 +: 10]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_max_unsigned();
    test_signed();
    test_start_held();
    test_start_ignored();
    test_reset_midrun();
    test_n4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
